// File: rtl/prog_mem_loader_if.sv
// Bundle of the loader's pin-side controls, load port and CPU fetch port.
// master drives the controls/program bytes; slave is the loader itself.
interface prog_mem_loader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              ena;
    logic              load_mode;
    logic              wr_strobe;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_data;
    logic              cpu_run;
    logic [ADDR_W:0]   prog_len;
    logic              full;

    modport master (
        output ena, load_mode, wr_strobe, wr_data, fetch_addr,
        input  fetch_data, cpu_run, prog_len, full
    );

    modport slave (
        input  ena, load_mode, wr_strobe, wr_data, fetch_addr,
        output fetch_data, cpu_run, prog_len, full
    );
endinterface

// File: rtl/prog_mem_loader.sv
// Flop-based program memory with a strobe-driven byte loader and a registered
// instruction fetch port feeding the 4-bit CPU core.
module prog_mem_loader #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    prog_mem_loader_if.slave   bus
);
    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                prev_r;
    logic                wr_edge_s;
    logic                we_s;
    logic                clear_s;
    logic [ADDR_W-1:0]   wr_ptr_r;
    logic [ADDR_W-1:0]   wr_ptr_next_s;
    logic [ADDR_W:0]     prog_len_r;
    logic [ADDR_W:0]     prog_len_next_s;
    logic                full_r;
    logic                full_next_s;
    logic                cpu_run_r;
    logic [DATA_W-1:0]   fetch_data_r;
    logic [DATA_W-1:0]   mem_r [DEPTH];

    // Strobe synchroniser and edge-detect flop; keeps shifting even when ena is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], bus.wr_strobe};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign wr_edge_s = sync_r[SYNC_STAGES-1] & ~prev_r;

    // Next-state and write-enable decode; nothing advances while ena is low
    always_comb begin
        next_state_s = state_r;
        clear_s      = 1'b0;
        we_s         = 1'b0;
        if (bus.ena) begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.load_mode) begin
                        next_state_s = ST_LOAD;
                        clear_s      = 1'b1;
                    end else begin
                        next_state_s = ST_RUN;
                    end
                end
                ST_LOAD: begin
                    // A write coinciding with the exit to RUN is still committed
                    we_s = wr_edge_s & ~full_r;
                    if (bus.load_mode) begin
                        next_state_s = ST_LOAD;
                    end else begin
                        next_state_s = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.load_mode) begin
                        next_state_s = ST_LOAD;
                        clear_s      = 1'b1;
                    end else begin
                        next_state_s = ST_RUN;
                    end
                end
                default: begin
                    next_state_s = ST_IDLE;
                end
            endcase
        end else begin
            next_state_s = state_r;
        end
    end

    // Write pointer / length bookkeeping; full tracks the length it is stored with
    always_comb begin
        wr_ptr_next_s   = wr_ptr_r;
        prog_len_next_s = prog_len_r;
        if (clear_s) begin
            wr_ptr_next_s   = {ADDR_W{1'b0}};
            prog_len_next_s = {(ADDR_W + 1){1'b0}};
        end else if (we_s) begin
            wr_ptr_next_s   = wr_ptr_r + {{(ADDR_W - 1){1'b0}}, 1'b1};
            prog_len_next_s = prog_len_r + {{ADDR_W{1'b0}}, 1'b1};
        end else begin
            wr_ptr_next_s   = wr_ptr_r;
            prog_len_next_s = prog_len_r;
        end
        full_next_s = (prog_len_next_s == LEN_MAX);
    end

    // Control state, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            wr_ptr_r     <= {ADDR_W{1'b0}};
            prog_len_r   <= {(ADDR_W + 1){1'b0}};
            full_r       <= 1'b0;
            cpu_run_r    <= 1'b0;
            fetch_data_r <= {DATA_W{1'b0}};
        end else if (bus.ena) begin
            state_r    <= next_state_s;
            wr_ptr_r   <= wr_ptr_next_s;
            prog_len_r <= prog_len_next_s;
            full_r     <= full_next_s;
            cpu_run_r  <= (next_state_s == ST_RUN);
            if (state_r == ST_RUN) begin
                fetch_data_r <= mem_r[bus.fetch_addr];
            end else begin
                fetch_data_r <= {DATA_W{1'b0}};
            end
        end else begin
            state_r <= state_r;
        end
    end

    // Program memory; every word clears on reset so stale code never survives it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (we_s) begin
            mem_r[wr_ptr_r] <= bus.wr_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    assign bus.fetch_data = fetch_data_r;
    assign bus.cpu_run    = cpu_run_r;
    assign bus.prog_len   = prog_len_r;
    assign bus.full       = full_r;
endmodule

// File: tb/tb_prog_mem_loader.sv
// Scoreboard bench for prog_mem_loader: a reference memory model predicts
// fetch results, which are queued at address drive and compared at output.
module tb_prog_mem_loader;
    logic clk;
    logic rst_n;

    prog_mem_loader_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    prog_mem_loader #(
        .ADDR_W      (4),
        .DATA_W      (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec  = 0;
    int         n_miss = 0;
    logic [7:0] exp_q [$];
    logic [7:0] model_mem [16];
    int         model_ptr = 0;
    int         model_len = 0;
    bit         model_in_load = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
        model_ptr     = 0;
        model_len     = 0;
        model_in_load = 1'b0;
    endtask

    // Change load_mode; cpu_run must only follow after the next edge
    task automatic set_mode(input bit load);
        @(negedge clk);
        bus.load_mode = load;
        check_eq("cpu_run_hold", {31'd0, bus.cpu_run}, {31'd0, ~model_in_load});
        @(negedge clk);
        model_in_load = load;
        if (load) begin
            model_ptr = 0;
            model_len = 0;
        end
        check_eq("cpu_run_new", {31'd0, bus.cpu_run}, {31'd0, ~load});
        check_eq("len_mode", {27'd0, bus.prog_len}, model_len);
    endtask

    // Raise the strobe for hold cycles; the write must land on the 3rd edge only
    task automatic strobe_write(input logic [7:0] data, input int hold);
        bit do_wr;
        do_wr = model_in_load && (model_len < 16);
        @(negedge clk);
        bus.wr_data   = data;
        bus.wr_strobe = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 check_eq("len_pre_wr", {27'd0, bus.prog_len}, model_len);
        @(posedge clk);
        if (do_wr) begin
            model_mem[model_ptr] = data;
            model_ptr = (model_ptr + 1) % 16;
            model_len++;
        end
        #1 check_eq("len_wr", {27'd0, bus.prog_len}, model_len);
        check_eq("full_wr", {31'd0, bus.full}, {31'd0, model_len == 16});
        for (int i = 3; i < hold; i++) begin
            @(posedge clk);
            #1 check_eq("len_hold", {27'd0, bus.prog_len}, model_len);
        end
        @(negedge clk);
        bus.wr_strobe = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Apply a fetch address, queue the model's word, compare one cycle later
    task automatic fetch(input logic [3:0] addr);
        logic [7:0] exp;
        @(negedge clk);
        bus.fetch_addr = addr;
        exp_q.push_back(model_in_load ? 8'h00 : model_mem[addr]);
        @(negedge clk);
        exp = exp_q.pop_front();
        check_eq($sformatf("fetch_%0d", addr), {24'd0, bus.fetch_data}, {24'd0, exp});
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_fd"},   {24'd0, bus.fetch_data}, 32'd0);
        check_eq({tag, "_run"},  {31'd0, bus.cpu_run},    32'd0);
        check_eq({tag, "_len"},  {27'd0, bus.prog_len},   32'd0);
        check_eq({tag, "_full"}, {31'd0, bus.full},       32'd0);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.ena        = 1'b1;
        bus.load_mode  = 1'b1;
        bus.wr_strobe  = 1'b0;
        bus.wr_data    = 8'h00;
        bus.fetch_addr = 4'h0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_state("rst0");
        rst_n = 1'b1;
        @(negedge clk);
        model_in_load = 1'b1;

        // Reset discards a partial load
        strobe_write(8'h11, 3);
        strobe_write(8'h22, 3);
        check_eq("t1_len2", {27'd0, bus.prog_len}, 32'd2);
        #2 rst_n = 1'b0;
        #1 check_reset_state("rst1");
        model_reset();
        bus.load_mode = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("t1_run", {31'd0, bus.cpu_run}, 32'd1);
        fetch(4'd0);
        fetch(4'd1);

        // Three-byte program then run
        set_mode(1'b1);
        strobe_write(8'hA1, 3);
        strobe_write(8'hB2, 3);
        strobe_write(8'hC3, 3);
        set_mode(1'b0);
        check_eq("t2_len", {27'd0, bus.prog_len}, 32'd3);
        for (int a = 0; a < 4; a++) fetch(4'(a));

        // Reload from RUN overwrites only address 0
        set_mode(1'b1);
        check_eq("t5_fd_nop", {24'd0, bus.fetch_data}, 32'd0);
        strobe_write(8'h5A, 3);
        check_eq("t5_len", {27'd0, bus.prog_len}, 32'd1);
        set_mode(1'b0);
        fetch(4'd0);
        fetch(4'd1);
        fetch(4'd2);

        // Held strobe gives exactly one write
        set_mode(1'b1);
        strobe_write(8'h77, 10);
        check_eq("t4_len", {27'd0, bus.prog_len}, 32'd1);

        // Strobe while disabled is discarded
        @(negedge clk);
        bus.ena       = 1'b0;
        bus.wr_data   = 8'h99;
        bus.wr_strobe = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("t6_len_off", {27'd0, bus.prog_len}, 32'd1);
        bus.wr_strobe = 1'b0;
        repeat (2) @(negedge clk);
        bus.ena = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("t6_len_on", {27'd0, bus.prog_len}, 32'd1);
        set_mode(1'b0);
        fetch(4'd0);
        fetch(4'd1);

        // Fill to capacity; the 17th byte must not wrap onto address 0
        set_mode(1'b1);
        for (int i = 0; i < 17; i++) begin
            strobe_write(8'(i), 3);
            if (i == 14) check_eq("t3_not_full", {31'd0, bus.full}, 32'd0);
            if (i == 15) check_eq("t3_full", {31'd0, bus.full}, 32'd1);
        end
        check_eq("t3_len", {27'd0, bus.prog_len}, 32'd16);
        check_eq("t3_full_end", {31'd0, bus.full}, 32'd1);
        set_mode(1'b0);
        fetch(4'd0);
        fetch(4'd1);
        fetch(4'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
